if_stage: RTL and testbench

//  Instruction fetch stage plus the IF/ID pipeline register. Keeps the fetch PC, issues
//  one instruction-memory read at a time over a valid/ready request and valid response

---
 rtl/if_stage.sv | 136 +++++++++++++
 tb/tb_if_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues one instruction-memory read at a time and holds the fetch PC.
// A decode stall is absorbed by a 1-entry skid buffer.
// A redirect from EX flushes IF/ID and the skid buffer, and marks any in-flight response as stale.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_take_branch,
    input  logic [31:0] ex_target_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic        if_id_valid_inst
);

    // REQ: issuing a read, WAIT: one read outstanding, FULL: skid buffer holds a word
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] inflight_pc_q;
    logic        drop_q;
    logic [31:0] skid_ir_q;
    logic [31:0] skid_pc_q;
    logic [31:0] ir_q;
    logic [31:0] pc_q;
    logic        valid_q;

    logic [31:0] target_pc_d;
    logic [31:0] fetch_pc_inc_d;
    logic        req_fire;

    // Redirect target is forced to word alignment; fetch PC wraps naturally at 2^32
    assign target_pc_d    = {ex_target_pc[31:2], 2'b00};
    assign fetch_pc_inc_d = fetch_pc_q + 32'd4;

    assign imem_req_valid = rst & (state_q == S_REQ) & ~ex_take_branch;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign if_id_IR         = ir_q;
    assign if_id_PC         = pc_q;
    assign if_id_valid_inst = valid_q;

    // Fetch FSM, skid buffer and IF/ID register; redirect overrides everything but reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= 32'd0;
            drop_q        <= 1'b0;
            skid_ir_q     <= NOP_INST;
            skid_pc_q     <= 32'd0;
            ir_q          <= NOP_INST;
            pc_q          <= 32'd0;
            valid_q       <= 1'b0;
        end else if (ex_take_branch) begin
            fetch_pc_q <= target_pc_d;
            // Flush IF/ID even under a decode stall; the PC field is left as is
            ir_q       <= NOP_INST;
            valid_q    <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        // The stale response lands this cycle: discard it now
                        state_q <= S_REQ;
                        drop_q  <= 1'b0;
                    end else begin
                        // Stale response still outstanding: discard it when it arrives
                        drop_q  <= 1'b1;
                    end
                end
                S_FULL: begin
                    // Skid contents are only meaningful in FULL, so leaving FULL empties it
                    skid_ir_q <= NOP_INST;
                    state_q   <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase
        end else begin
            // Bubble by default when decode advances; a load below overrides it
            if (!id_stall) begin
                ir_q    <= NOP_INST;
                valid_q <= 1'b0;
            end
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        inflight_pc_q <= fetch_pc_q;
                        fetch_pc_q    <= fetch_pc_inc_d;
                        state_q       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (!id_stall) begin
                            ir_q    <= imem_resp_data;
                            pc_q    <= inflight_pc_q;
                            valid_q <= 1'b1;
                            state_q <= S_REQ;
                        end else begin
                            skid_ir_q <= imem_resp_data;
                            skid_pc_q <= inflight_pc_q;
                            state_q   <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!id_stall) begin
                        ir_q    <= skid_ir_q;
                        pc_q    <= skid_pc_q;
                        valid_q <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage.
// Each vector drives one cycle of inputs and checks two things:
// the request outputs before the clock edge, and the IF/ID register after it.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        ex_take_branch;
    logic [31:0] ex_target_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] if_id_IR;
    logic [31:0] if_id_PC;
    logic        if_id_valid_inst;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_stall        (id_stall),
        .ex_take_branch  (ex_take_branch),
        .ex_target_pc    (ex_target_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_id_IR        (if_id_IR),
        .if_id_PC        (if_id_PC),
        .if_id_valid_inst(if_id_valid_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_v;
        logic [31:0] e_ir;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic stall, logic br, logic [31:0] tgt, logic rdy,
                                logic rv, logic [31:0] rd, logic e_rv, logic [31:0] e_ra,
                                logic e_v, logic [31:0] e_ir, logic [31:0] e_pc);
        vec_t v;
        v.stall = stall; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_rv = e_rv; v.e_ra = e_ra; v.e_v = e_v; v.e_ir = e_ir; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector, check request side mid-cycle, IF/ID side after the edge
    task automatic step(input vec_t v, input int idx);
        id_stall        = v.stall;
        ex_take_branch  = v.br;
        ex_target_pc    = v.tgt;
        imem_req_ready  = v.rdy;
        imem_resp_valid = v.rv;
        imem_resp_data  = v.rd;
        @(negedge clk);
        chk("req_valid", idx, {31'd0, imem_req_valid}, {31'd0, v.e_rv});
        chk("req_addr", idx, imem_req_addr, v.e_ra);
        @(posedge clk);
        #1;
        chk("if_id_valid", idx, {31'd0, if_id_valid_inst}, {31'd0, v.e_v});
        chk("if_id_IR", idx, if_id_IR, v.e_ir);
        chk("if_id_PC", idx, if_id_PC, v.e_pc);
        $display("step %0d: st=%0b br=%0b rdy=%0b rv=%0b req=%0b addr=%h valid=%0b IR=%h PC=%h",
                 idx, v.stall, v.br, v.rdy, v.rv, imem_req_valid, imem_req_addr,
                 if_id_valid_inst, if_id_IR, if_id_PC);
    endtask

    initial begin
        // stall br tgt rdy rv rd | e_req e_addr | e_valid e_IR e_PC
        // T1: back-to-back fetches from reset with 1-cycle memory
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h0,   0,NOP,0));
        tbl.push_back(mk(0,0,0,1,1,32'hD000_0000,0,32'h4,   1,32'hD000_0000,32'h0));
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h4,   0,NOP,32'h0));
        tbl.push_back(mk(0,0,0,1,1,32'hD000_0004,0,32'h8,   1,32'hD000_0004,32'h4));
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h8,   0,NOP,32'h4));
        // T2: response for PC 8 under a 3-cycle stall goes to skid, released later
        tbl.push_back(mk(1,0,0,1,1,32'hD000_0008,0,32'hC,   0,NOP,32'h4));
        tbl.push_back(mk(1,0,0,1,0,0,            0,32'hC,   0,NOP,32'h4));
        tbl.push_back(mk(1,0,0,1,0,0,            0,32'hC,   0,NOP,32'h4));
        tbl.push_back(mk(0,0,0,1,0,0,            0,32'hC,   1,32'hD000_0008,32'h8));
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'hC,   0,NOP,32'h8));
        // T3: redirect while waiting; stale response arrives two cycles later
        tbl.push_back(mk(0,1,32'h103,1,0,0,      0,32'h10,  0,NOP,32'h8));
        tbl.push_back(mk(0,0,0,1,0,0,            0,32'h100, 0,NOP,32'h8));
        tbl.push_back(mk(0,0,0,1,1,32'hBAD0_000C,0,32'h100, 0,NOP,32'h8));
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h100, 0,NOP,32'h8));
        tbl.push_back(mk(0,0,0,1,1,32'hD000_0100,0,32'h104, 1,32'hD000_0100,32'h100));
        // T4: redirect plus stall with valid IF/ID flushes anyway
        tbl.push_back(mk(1,1,32'h200,1,0,0,      0,32'h104, 0,NOP,32'h100));
        // T5: request held while memory not ready
        tbl.push_back(mk(0,0,0,0,0,0,            1,32'h200, 0,NOP,32'h100));
        tbl.push_back(mk(0,0,0,0,0,0,            1,32'h200, 0,NOP,32'h100));
        tbl.push_back(mk(0,0,0,0,0,0,            1,32'h200, 0,NOP,32'h100));
        tbl.push_back(mk(0,0,0,0,0,0,            1,32'h200, 0,NOP,32'h100));
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h200, 0,NOP,32'h100));
        tbl.push_back(mk(0,0,0,1,1,32'hD000_0200,0,32'h204, 1,32'hD000_0200,32'h200));
        // T6: redirect to top of address space, fetch PC wraps to 0
        tbl.push_back(mk(0,1,32'hFFFF_FFFC,1,0,0,0,32'h204, 0,NOP,32'h200));
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'hFFFF_FFFC, 0,NOP,32'h200));
        tbl.push_back(mk(0,0,0,1,1,32'hD0FF_FFFC,0,32'h0,   1,32'hD0FF_FFFC,32'hFFFF_FFFC));
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h0,   0,NOP,32'hFFFF_FFFC));
        tbl.push_back(mk(0,0,0,1,1,32'hD100_0000,0,32'h4,   1,32'hD100_0000,32'h0));
        // Redirect while FULL clears the skid buffer
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h4,   0,NOP,32'h0));
        tbl.push_back(mk(1,0,0,1,1,32'hBAD0_0004,0,32'h8,   0,NOP,32'h0));
        tbl.push_back(mk(1,1,32'h40,1,0,0,       0,32'h8,   0,NOP,32'h0));
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h40,  0,NOP,32'h0));
        tbl.push_back(mk(0,0,0,1,1,32'hD000_0040,0,32'h44,  1,32'hD000_0040,32'h40));
        // Redirect coinciding with the response: discarded, no lingering drop
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h44,  0,NOP,32'h40));
        tbl.push_back(mk(0,1,32'h80,1,1,32'hBAD0_0044,0,32'h48, 0,NOP,32'h40));
        tbl.push_back(mk(0,0,0,1,0,0,            1,32'h80,  0,NOP,32'h40));
        tbl.push_back(mk(0,0,0,1,1,32'hD000_0080,0,32'h84,  1,32'hD000_0080,32'h80));
        // Response outside WAIT is ignored
        tbl.push_back(mk(0,0,0,0,1,32'hBAD0_0084,1,32'h84,  0,NOP,32'h80));

        // Reset: two cycles low, request must stay deasserted
        rst = 1'b0; id_stall = 1'b0; ex_take_branch = 1'b0; ex_target_pc = 32'd0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", -1, {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_valid", -1, {31'd0, if_id_valid_inst}, 32'd0);
        chk("rst_IR", -1, if_id_IR, NOP);
        chk("rst_PC", -1, if_id_PC, 32'd0);
        $display("reset: req=%0b valid=%0b IR=%h PC=%h", imem_req_valid, if_id_valid_inst,
                 if_id_IR, if_id_PC);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Reset asserted with a request in flight returns to RESET_PC in REQ
        step(mk(0,0,0,1,0,0, 1,32'h84, 0,NOP,32'h80), 100);
        rst = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("midrst_req_valid", 101, {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_valid", 101, {31'd0, if_id_valid_inst}, 32'd0);
        chk("midrst_PC", 101, if_id_PC, 32'd0);
        $display("mid-reset: valid=%0b PC=%h", if_id_valid_inst, if_id_PC);
        rst = 1'b1;
        step(mk(0,0,0,0,0,0, 1,32'h0, 0,NOP,32'h0), 102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
